// File: rtl/fetch_warp_scheduler.sv
// fetch_warp_scheduler: round-robin fetch grant arbiter with per-warp branch-pending tracking.
//   in : clk, rst_n (sync, active-low), warp_active, ibuf_full, br_dec_valid/br_dec_warp,
//        br_res_valid/br_res_warp, fetch_ack
//   out: grant_valid, grant_onehot, grant_warp (registered grant), pending_mask
module fetch_warp_scheduler #(
  parameter int NUM_WARPS = 8,
  localparam int WID = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WARPS-1:0] warp_active,
  input  logic [NUM_WARPS-1:0] ibuf_full,
  input  logic                 br_dec_valid,
  input  logic [WID-1:0]       br_dec_warp,
  input  logic                 br_res_valid,
  input  logic [WID-1:0]       br_res_warp,
  input  logic                 fetch_ack,
  output logic                 grant_valid,
  output logic [NUM_WARPS-1:0] grant_onehot,
  output logic [WID-1:0]       grant_warp,
  output logic [NUM_WARPS-1:0] pending_mask
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [WID-1:0] rr_ptr_q, rr_ptr_d, warp_q, warp_d, start, pick, idx;
  logic [NUM_WARPS-1:0] onehot_q, onehot_d, pending_q, pending_d, elig;
  logic found, reissue;
  always_comb begin
    elig = warp_active & ~ibuf_full & ~pending_q;
    // an ack in GRANT (or any IDLE cycle) triggers a fresh circular search
    reissue = (state_q == IDLE) || fetch_ack;
    start = (state_q == GRANT) ? warp_q + WID'(1) : rr_ptr_q;
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = start + WID'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
    state_d = state_q;
    warp_d = warp_q;
    onehot_d = onehot_q;
    rr_ptr_d = rr_ptr_q;
    if (reissue) begin
      rr_ptr_d = (state_q == GRANT) ? start : rr_ptr_q;
      state_d = found ? GRANT : IDLE;
      warp_d = found ? pick : '0;
      onehot_d = found ? NUM_WARPS'(1) << pick : '0;
    end else if (!elig[warp_q]) begin
      state_d = IDLE;
      warp_d = '0;
      onehot_d = '0;
    end
    for (int i = 0; i < NUM_WARPS; i++)
      pending_d[i] = warp_active[i] & ((br_dec_valid && br_dec_warp == WID'(i)) |
                     (pending_q[i] & !(br_res_valid && br_res_warp == WID'(i))));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      warp_q <= '0;
      onehot_q <= '0;
      pending_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      warp_q <= warp_d;
      onehot_q <= onehot_d;
      pending_q <= pending_d;
    end
  end
  assign grant_valid = (state_q == GRANT);
  assign grant_onehot = onehot_q;
  assign grant_warp = warp_q;
  assign pending_mask = pending_q;
endmodule
